// File: rtl/oven_countdown_timer.sv
// rtl/oven_countdown_timer.sv - BCD MM:SS countdown timer with start/pause/cancel and completion pulse
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   set_time          BCD time to load (sanitised on load)
//   load              strobe: load set_time (ignored while running)
//   start             strobe: start from IDLE or resume from PAUSED
//   pause             strobe: pause a running countdown
//   cancel            strobe: abort and clear, highest priority
//   digit_time        remaining time in BCD
//   running/paused/done  state flags
//   timeout           one-cycle pulse when the count reaches zero
module oven_countdown_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] set_time,
    input  logic                  load,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  cancel,
    output logic [4*N_DIGITS-1:0] digit_time,
    output logic                  running,
    output logic                  paused,
    output logic                  done,
    output logic                  timeout
);

    localparam int DW = 4 * N_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PAUSED,
        ST_DONE
    } state_t;

    state_t          state, state_n;
    logic [DW-1:0]   time_n;
    logic [DW-1:0]   dec_time;
    logic [PW-1:0]   presc, presc_n;
    logic            timeout_n;
    logic            tick;

    // Clamp every digit to 9 and the seconds-tens digit to 5.
    function automatic logic [DW-1:0] sanitize(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic [3:0]    d;
        r = v;
        for (int i = 0; i < N_DIGITS; i++) begin
            d = v[i*4 +: 4];
            if (d > 4'd9) d = 4'd9;
            if (i == 1 && d > 4'd5) d = 4'd5;
            r[i*4 +: 4] = d;
        end
        return r;
    endfunction

    // One-second BCD decrement; zero saturates instead of wrapping to all-9s.
    function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic [3:0]    d;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        if (v != '0) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                d = v[i*4 +: 4];
                if (borrow) begin
                    if (d == 4'd0) begin
                        d = (i == 1) ? 4'd5 : 4'd9;
                    end else begin
                        d      = d - 4'd1;
                        borrow = 1'b0;
                    end
                end
                r[i*4 +: 4] = d;
            end
        end
        return r;
    endfunction

    assign tick     = (presc == PRESC_LAST);
    assign dec_time = bcd_dec(digit_time);

    always_comb begin
        state_n   = state;
        time_n    = digit_time;
        presc_n   = presc;
        timeout_n = 1'b0;
        if (cancel) begin
            state_n = ST_IDLE;
            time_n  = '0;
            presc_n = '0;
        end else if (state == ST_RUNNING) begin
            // The run step (prescaler advance and any tick decrement) is taken
            // even on the edge that pauses, so no run cycle is lost.
            if (tick) begin
                presc_n = '0;
                time_n  = dec_time;
            end else begin
                presc_n = presc + PW'(1);
            end
            if (tick && dec_time == '0) begin
                state_n   = ST_DONE;
                timeout_n = 1'b1;
            end else if (pause) begin
                state_n = ST_PAUSED;
            end
        end else if (start && state != ST_DONE && digit_time != '0) begin
            state_n = ST_RUNNING;
            // Resuming from PAUSED keeps the partial second already counted.
            if (state == ST_IDLE) presc_n = '0;
        end else if (load) begin
            state_n = ST_IDLE;
            time_n  = sanitize(set_time);
            presc_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            digit_time <= '0;
            presc      <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            digit_time <= time_n;
            presc      <= presc_n;
            timeout    <= timeout_n;
        end
    end

    assign running = (state == ST_RUNNING);
    assign paused  = (state == ST_PAUSED);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_oven_countdown_timer.sv
// tb/tb_oven_countdown_timer.sv - self-checking bench for oven_countdown_timer
module tb_oven_countdown_timer;

    localparam int TICK = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] set_time;
    logic        load, start, pause, cancel;
    logic [15:0] digit_time;
    logic        running, paused, done, timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: remaining time as a plain number of seconds.
    int m_mode = M_IDLE;
    int m_secs = 0;
    int m_cnt  = 0;
    int m_to   = 0;

    typedef struct {
        logic [3:0]  ctl;    // {load, start, pause, cancel}
        logic [15:0] val;
        logic [15:0] e_dt;
        logic [3:0]  e_fl;   // {running, paused, done, timeout}
    } vec_t;

    vec_t vecs[25];

    oven_countdown_timer #(.TICK_DIV(TICK), .N_DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_time  (set_time),
        .load      (load),
        .start     (start),
        .pause     (pause),
        .cancel    (cancel),
        .digit_time(digit_time),
        .running   (running),
        .paused    (paused),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic [3:0] ctl, input logic [15:0] val,
                                 input logic [15:0] e_dt, input logic [3:0] e_fl);
        vec_t r;
        r.ctl  = ctl;
        r.val  = val;
        r.e_dt = e_dt;
        r.e_fl = e_fl;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m, sc;
        m  = s / 60;
        sc = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic int sanitize_secs(input logic [15:0] x);
        int d[4];
        for (int i = 0; i < 4; i++) begin
            d[i] = int'(x[i*4 +: 4]);
            if (d[i] > 9) d[i] = 9;
        end
        if (d[1] > 5) d[1] = 5;
        return (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_secs = 0;
        m_cnt  = 0;
        m_to   = 0;
    endtask

    task automatic model_step(input logic ld, input logic st, input logic pa,
                              input logic ca, input logic [15:0] val);
        m_to = 0;
        if (ca) begin
            m_mode = M_IDLE;
            m_secs = 0;
            m_cnt  = 0;
        end else if (m_mode == M_RUN) begin
            m_cnt++;
            if (m_cnt == TICK) begin
                m_cnt = 0;
                m_secs--;
            end
            if (m_secs == 0) begin
                m_mode = M_DONE;
                m_to   = 1;
            end else if (pa) begin
                m_mode = M_PAUSE;
            end
        end else if (st && m_mode != M_DONE && m_secs != 0) begin
            if (m_mode == M_IDLE) m_cnt = 0;
            m_mode = M_RUN;
        end else if (ld) begin
            m_secs = sanitize_secs(val);
            m_mode = M_IDLE;
            m_cnt  = 0;
        end
    endtask

    task automatic check_model();
        chk("model digit_time", 32'(digit_time), 32'(to_bcd(m_secs)));
        chk("model running", 32'(running), 32'(m_mode == M_RUN));
        chk("model paused", 32'(paused), 32'(m_mode == M_PAUSE));
        chk("model done", 32'(done), 32'(m_mode == M_DONE));
        chk("model timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic step(input logic [3:0] ctl, input logic [15:0] val);
        load     = ctl[3];
        start    = ctl[2];
        pause    = ctl[1];
        cancel   = ctl[0];
        set_time = val;
        @(posedge clk);
        model_step(ctl[3], ctl[2], ctl[1], ctl[0], val);
        #1;
        check_model();
        load   = 1'b0;
        start  = 1'b0;
        pause  = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 16'h0000);
    endtask

    initial begin
        int zero_at;
        int pulses;
        logic [3:0] c;

        vecs[0]  = mkv(4'b1000, 16'h0A7C, 16'h0959, 4'b0000);
        vecs[1]  = mkv(4'b1000, 16'h0013, 16'h0013, 4'b0000);
        vecs[2]  = mkv(4'b0100, 16'h0000, 16'h0013, 4'b1000);
        vecs[3]  = mkv(4'b0000, 16'h0000, 16'h0013, 4'b1000);
        vecs[4]  = mkv(4'b0000, 16'h0000, 16'h0013, 4'b1000);
        vecs[5]  = mkv(4'b0000, 16'h0000, 16'h0013, 4'b1000);
        vecs[6]  = mkv(4'b0000, 16'h0000, 16'h0012, 4'b1000);
        vecs[7]  = mkv(4'b0001, 16'h0000, 16'h0000, 4'b0000);
        vecs[8]  = mkv(4'b0100, 16'h0000, 16'h0000, 4'b0000);
        vecs[9]  = mkv(4'b1000, 16'h0100, 16'h0100, 4'b0000);
        vecs[10] = mkv(4'b0100, 16'h0000, 16'h0100, 4'b1000);
        vecs[11] = mkv(4'b0000, 16'h0000, 16'h0100, 4'b1000);
        vecs[12] = mkv(4'b0000, 16'h0000, 16'h0100, 4'b1000);
        vecs[13] = mkv(4'b0000, 16'h0000, 16'h0100, 4'b1000);
        vecs[14] = mkv(4'b0000, 16'h0000, 16'h0059, 4'b1000);
        vecs[15] = mkv(4'b1000, 16'h0200, 16'h0059, 4'b1000);
        vecs[16] = mkv(4'b0110, 16'h0000, 16'h0059, 4'b0100);
        vecs[17] = mkv(4'b0001, 16'h0000, 16'h0000, 4'b0000);
        vecs[18] = mkv(4'b1000, 16'h1000, 16'h1000, 4'b0000);
        vecs[19] = mkv(4'b0100, 16'h0000, 16'h1000, 4'b1000);
        vecs[20] = mkv(4'b0000, 16'h0000, 16'h1000, 4'b1000);
        vecs[21] = mkv(4'b0000, 16'h0000, 16'h1000, 4'b1000);
        vecs[22] = mkv(4'b0000, 16'h0000, 16'h1000, 4'b1000);
        vecs[23] = mkv(4'b0000, 16'h0000, 16'h0959, 4'b1000);
        vecs[24] = mkv(4'b0001, 16'h0000, 16'h0000, 4'b0000);

        rst_n    = 1'b0;
        set_time = 16'h0000;
        load     = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        cancel   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset digit_time", 32'(digit_time), 32'h0);
        chk("reset flags", 32'({running, paused, done, timeout}), 32'h0);

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].ctl, vecs[i].val);
            chk($sformatf("vec%0d digit_time", i), 32'(digit_time), 32'(vecs[i].e_dt));
            chk($sformatf("vec%0d flags", i), 32'({running, paused, done, timeout}),
                32'(vecs[i].e_fl));
        end

        // Full countdown of 13 s: zero and the timeout pulse land 52 cycles after start.
        step(4'b1000, 16'h0013);
        step(4'b0100, 16'h0000);
        zero_at = -1;
        pulses  = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            step(4'b0000, 16'h0000);
            if (timeout) pulses++;
            if (digit_time == 16'h0000 && zero_at < 0) zero_at = cyc;
        end
        chk("countdown zero cycle", 32'(zero_at), 32'd52);
        chk("countdown timeout pulses", 32'(pulses), 32'd1);
        chk("countdown done", 32'({running, done}), 32'b01);

        // Load from DONE returns to IDLE.
        step(4'b1000, 16'h0002);
        chk("done load digit_time", 32'(digit_time), 32'h0002);
        chk("done load flags", 32'({running, paused, done, timeout}), 32'h0);
        step(4'b0001, 16'h0000);

        // Pause after 6 run cycles, hold 20 cycles, resume: next tick 2 cycles later.
        step(4'b1000, 16'h0005);
        step(4'b0100, 16'h0000);
        nops(5);
        step(4'b0010, 16'h0000);
        chk("pause digit_time", 32'(digit_time), 32'h0004);
        chk("pause flag", 32'(paused), 32'd1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0000, 16'h0000);
            if (digit_time != 16'h0004 || !paused) pulses++;
        end
        chk("pause frozen cycles changed", 32'(pulses), 32'd0);
        step(4'b0100, 16'h0000);
        chk("resume digit_time r", 32'(digit_time), 32'h0004);
        step(4'b0000, 16'h0000);
        chk("resume digit_time r+1", 32'(digit_time), 32'h0004);
        step(4'b0000, 16'h0000);
        chk("resume digit_time r+2", 32'(digit_time), 32'h0003);
        step(4'b0001, 16'h0000);

        // Pause on a tick edge: that edge's decrement still lands.
        step(4'b1000, 16'h0002);
        step(4'b0100, 16'h0000);
        nops(3);
        step(4'b0010, 16'h0000);
        chk("pause on tick digit_time", 32'(digit_time), 32'h0001);
        chk("pause on tick paused", 32'(paused), 32'd1);
        step(4'b0001, 16'h0000);

        // Cancel on the final tick: no timeout, back to IDLE.
        step(4'b1000, 16'h0001);
        step(4'b0100, 16'h0000);
        nops(3);
        step(4'b0001, 16'h0000);
        chk("cancel tick digit_time", 32'(digit_time), 32'h0000);
        chk("cancel tick flags", 32'({running, paused, done, timeout}), 32'h0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 16'h0000);
            if (timeout) pulses++;
        end
        chk("cancel tick late timeout", 32'(pulses), 32'd0);

        // Asynchronous reset mid-run clears outputs before the next edge.
        step(4'b1000, 16'h0013);
        step(4'b0100, 16'h0000);
        nops(7);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset digit_time", 32'(digit_time), 32'h0);
        chk("async reset flags", 32'({running, paused, done, timeout}), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 16'h0000);
            if (digit_time != 16'h0000 || running) pulses++;
        end
        chk("post reset idle changes", 32'(pulses), 32'd0);

        // Randomised control traffic checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            c[3] = ($urandom_range(0, 9) == 0);
            c[2] = ($urandom_range(0, 7) == 0);
            c[1] = ($urandom_range(0, 19) == 0);
            c[0] = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0)
                step(c, 16'($urandom));
            else
                step(c, {8'h00, 4'($urandom_range(0, 2)), 4'($urandom)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
